// File: rtl/qspi_seq_pkg.sv
// Shared definitions for the QSPI flash operation sequencer.
// Holds flash opcodes, the operation-type and FSM state encodings, flag status
// register bit positions and the operation validation rule.
package qspi_seq_pkg;

    // Flash opcodes issued through the shift engine
    localparam logic [7:0] CmdWren = 8'h06;
    localparam logic [7:0] CmdPp   = 8'h02;
    localparam logic [7:0] CmdSe   = 8'hD8;
    localparam logic [7:0] CmdBe   = 8'hC7;
    localparam logic [7:0] CmdRfsr = 8'h70;

    // Flag status register bit positions
    localparam int unsigned FsrReady    = 7;
    localparam int unsigned FsrEraseErr = 5;
    localparam int unsigned FsrProgErr  = 4;

    typedef enum logic [1:0] {
        OpPp   = 2'd0,
        OpSe   = 2'd1,
        OpBe   = 2'd2,
        OpRsvd = 2'd3
    } op_type_e;

    typedef enum logic [3:0] {
        StIdle,
        StWrenIssue,
        StWrenWait,
        StOpIssue,
        StOpWait,
        StGap,
        StPollIssue,
        StPollWait,
        StDone
    } state_e;

    // A page program must stay inside one 256-byte page and carry 1..256 bytes.
    function automatic logic op_is_invalid(logic [1:0] op_type, logic [7:0] page_off,
                                           logic [8:0] len);
        logic [9:0] end_off;
        end_off = {2'b00, page_off} + {1'b0, len};
        if (op_type == OpRsvd) begin
            return 1'b1;
        end
        if (op_type == OpPp) begin
            return (len == 9'd0) || (len > 9'd256) || (end_off > 10'd256);
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/qspi_poll_timer.sv
// Poll pacing for the flash operation sequencer.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-high reset
//   gap_run        high while the sequencer sits in its inter-poll gap
//   gap_done       high in the last of POLL_GAP gap cycles
//   poll_clear     zero the poll counter
//   poll_inc       count one issued status poll (saturating at 16 bits)
//   poll_at_limit  poll counter equals MAX_POLLS
module qspi_poll_timer #(
    parameter int unsigned POLL_GAP  = 8,
    parameter int unsigned MAX_POLLS = 65535
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic gap_run,
    output logic gap_done,
    input  logic poll_clear,
    input  logic poll_inc,
    output logic poll_at_limit
);

    localparam int unsigned GapW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
    logic [15:0]     poll_cnt_q, poll_cnt_d;

    // The gap counter restarts whenever the sequencer leaves the gap state.
    always_comb begin
        gap_cnt_d = '0;
        gap_done  = 1'b0;
        if (gap_run) begin
            if (gap_cnt_q == GapW'(POLL_GAP - 1)) begin
                gap_done = 1'b1;
            end else begin
                gap_cnt_d = gap_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        poll_cnt_d = poll_cnt_q;
        if (poll_clear) begin
            poll_cnt_d = '0;
        end else if (poll_inc && (poll_cnt_q != 16'hFFFF)) begin
            poll_cnt_d = poll_cnt_q + 16'd1;
        end
    end

    assign poll_at_limit = (poll_cnt_q == 16'(MAX_POLLS));

    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            gap_cnt_q  <= '0;
            poll_cnt_q <= '0;
        end else begin
            gap_cnt_q  <= gap_cnt_d;
            poll_cnt_q <= poll_cnt_d;
        end
    end

endmodule

// File: rtl/qspi_flash_op_sequencer.sv
// Sequences page program / sector erase / bulk erase on the QSPI shift engine:
// WREN, the operation opcode, then RFSR polling until the flash reports ready.
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-high reset
//   op_*                    operation request from the front end (valid/ready)
//   done_o, err_o, timeout_o one-cycle completion pulse with status
//   busy_o                  sequencer not idle
//   eng_*                   transaction request/response to the shift engine
module qspi_flash_op_sequencer
    import qspi_seq_pkg::*;
#(
    parameter int unsigned ADDR_W    = 24,
    parameter int unsigned POLL_GAP  = 8,
    parameter int unsigned MAX_POLLS = 65535
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              op_valid_i,
    output logic              op_ready_o,
    input  logic [1:0]        op_type_i,
    input  logic [ADDR_W-1:0] op_addr_i,
    input  logic [8:0]        op_len_i,
    output logic              done_o,
    output logic              err_o,
    output logic              timeout_o,
    output logic              busy_o,
    output logic              eng_valid_o,
    input  logic              eng_ready_i,
    output logic [7:0]        eng_cmd_o,
    output logic              eng_has_addr_o,
    output logic [ADDR_W-1:0] eng_addr_o,
    output logic [8:0]        eng_len_o,
    output logic              eng_dir_o,
    input  logic              eng_done_i,
    input  logic [7:0]        eng_rdata_i
);

    state_e            state_q, state_d;
    op_type_e          op_type_q, op_type_d;
    logic [ADDR_W-1:0] op_addr_q, op_addr_d;
    logic [8:0]        op_len_q, op_len_d;
    logic              err_q, err_d;
    logic              timeout_q, timeout_d;

    logic gap_done, poll_clear, poll_inc, poll_at_limit;
    logic reject;

    assign reject = op_is_invalid(op_type_i, op_addr_i[7:0], op_len_i);

    qspi_poll_timer #(
        .POLL_GAP  (POLL_GAP),
        .MAX_POLLS (MAX_POLLS)
    ) u_poll_timer (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .gap_run       (state_q == StGap),
        .gap_done      (gap_done),
        .poll_clear    (poll_clear),
        .poll_inc      (poll_inc),
        .poll_at_limit (poll_at_limit)
    );

    always_comb begin
        state_d        = state_q;
        op_type_d      = op_type_q;
        op_addr_d      = op_addr_q;
        op_len_d       = op_len_q;
        err_d          = err_q;
        timeout_d      = timeout_q;
        poll_clear     = 1'b0;
        poll_inc       = 1'b0;
        op_ready_o     = 1'b0;
        done_o         = 1'b0;
        err_o          = 1'b0;
        timeout_o      = 1'b0;
        busy_o         = (state_q != StIdle);
        eng_valid_o    = 1'b0;
        eng_cmd_o      = 8'h00;
        eng_has_addr_o = 1'b0;
        eng_addr_o     = '0;
        eng_len_o      = 9'd0;
        eng_dir_o      = 1'b0;

        unique case (state_q)
            StIdle: begin
                op_ready_o = 1'b1;
                if (op_valid_i) begin
                    op_type_d = op_type_e'(op_type_i);
                    op_addr_d = op_addr_i;
                    op_len_d  = op_len_i;
                    err_d     = reject;
                    timeout_d = 1'b0;
                    state_d   = reject ? StDone : StWrenIssue;
                end
            end
            StWrenIssue: begin
                eng_valid_o = 1'b1;
                eng_cmd_o   = CmdWren;
                if (eng_ready_i) state_d = StWrenWait;
            end
            StWrenWait: begin
                if (eng_done_i) state_d = StOpIssue;
            end
            StOpIssue: begin
                eng_valid_o = 1'b1;
                unique case (op_type_q)
                    OpPp: begin
                        eng_cmd_o      = CmdPp;
                        eng_has_addr_o = 1'b1;
                        eng_addr_o     = op_addr_q;
                        eng_len_o      = op_len_q;
                    end
                    OpSe: begin
                        eng_cmd_o      = CmdSe;
                        eng_has_addr_o = 1'b1;
                        eng_addr_o     = op_addr_q;
                    end
                    default: begin
                        eng_cmd_o = CmdBe;
                    end
                endcase
                if (eng_ready_i) state_d = StOpWait;
            end
            StOpWait: begin
                if (eng_done_i) begin
                    poll_clear = 1'b1;
                    state_d    = StGap;
                end
            end
            StGap: begin
                if (gap_done) state_d = StPollIssue;
            end
            StPollIssue: begin
                eng_valid_o = 1'b1;
                eng_cmd_o   = CmdRfsr;
                eng_len_o   = 9'd1;
                eng_dir_o   = 1'b1;
                if (eng_ready_i) begin
                    poll_inc = 1'b1;
                    state_d  = StPollWait;
                end
            end
            StPollWait: begin
                if (eng_done_i) begin
                    // Ready takes precedence over the poll limit on the final poll.
                    if (eng_rdata_i[FsrReady]) begin
                        err_d   = eng_rdata_i[FsrProgErr] | eng_rdata_i[FsrEraseErr];
                        state_d = StDone;
                    end else if (poll_at_limit) begin
                        err_d     = 1'b1;
                        timeout_d = 1'b1;
                        state_d   = StDone;
                    end else begin
                        state_d = StGap;
                    end
                end
            end
            StDone: begin
                done_o    = 1'b1;
                err_o     = err_q;
                timeout_o = timeout_q;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            state_q   <= StIdle;
            op_type_q <= OpPp;
            op_addr_q <= '0;
            op_len_q  <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_type_q <= op_type_d;
            op_addr_q <= op_addr_d;
            op_len_q  <= op_len_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: tb/tb_qspi_flash_op_sequencer.sv
// Self-checking bench for qspi_flash_op_sequencer: a directed table of
// operations, randomized operations against a transaction-level reference
// model, and hand-written stall and mid-operation reset sequences.
module tb_qspi_flash_op_sequencer;

    localparam int unsigned POLL_GAP  = 3;
    localparam int unsigned MAX_POLLS = 4;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b1;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [1:0]  op_type = '0;
    logic [23:0] op_addr = '0;
    logic [8:0]  op_len = '0;
    logic        done, err, timeout, busy;
    logic        eng_valid;
    logic        eng_ready = 1'b0;
    logic [7:0]  eng_cmd;
    logic        eng_has_addr;
    logic [23:0] eng_addr;
    logic [8:0]  eng_len;
    logic        eng_dir;
    logic        eng_done = 1'b0;
    logic [7:0]  eng_rdata = '0;

    always #5 clk = ~clk;

    qspi_flash_op_sequencer #(
        .ADDR_W    (24),
        .POLL_GAP  (POLL_GAP),
        .MAX_POLLS (MAX_POLLS)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .op_valid_i     (op_valid),
        .op_ready_o     (op_ready),
        .op_type_i      (op_type),
        .op_addr_i      (op_addr),
        .op_len_i       (op_len),
        .done_o         (done),
        .err_o          (err),
        .timeout_o      (timeout),
        .busy_o         (busy),
        .eng_valid_o    (eng_valid),
        .eng_ready_i    (eng_ready),
        .eng_cmd_o      (eng_cmd),
        .eng_has_addr_o (eng_has_addr),
        .eng_addr_o     (eng_addr),
        .eng_len_o      (eng_len),
        .eng_dir_o      (eng_dir),
        .eng_done_i     (eng_done),
        .eng_rdata_i    (eng_rdata)
    );

    typedef struct {
        logic [7:0]  cmd;
        logic        has_addr;
        logic [23:0] addr;
        logic [8:0]  len;
        logic        dir;
    } tx_t;

    typedef struct {
        logic [1:0]       t;
        logic [23:0]      a;
        logic [8:0]       l;
        int               dly;
        bit               hold;
        int               nf;
        logic [0:5][7:0]  fb;
        bit               exp_err;
        bit               exp_to;
        int               exp_ntx;
    } vec_t;

    int errors = 0;
    int checks = 0;

    tx_t        got_q[$];
    tx_t        exp_q[$];
    logic [7:0] fsr_script[$];
    int         fsr_idx;
    bit         m_rej, m_err, m_to;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic tx_t mk_tx(logic [7:0] c, logic h, logic [23:0] a, logic [8:0] l,
                                  logic d);
        tx_t x;
        x.cmd = c; x.has_addr = h; x.addr = a; x.len = l; x.dir = d;
        return x;
    endfunction

    // Reference: the transaction list and outcome an operation must produce,
    // given the status bytes the flash will return.
    task automatic model(input logic [1:0] t, input logic [23:0] a, input logic [8:0] l);
        logic [7:0] f;
        exp_q.delete();
        m_err = 0;
        m_to  = 0;
        m_rej = (t == 2'd3) ||
                ((t == 2'd0) && (l == 0 || l > 256 || int'(a[7:0]) + int'(l) > 256));
        if (m_rej) begin
            m_err = 1;
            return;
        end
        exp_q.push_back(mk_tx(8'h06, 0, 0, 0, 0));
        case (t)
            2'd0:    exp_q.push_back(mk_tx(8'h02, 1, a, l, 0));
            2'd1:    exp_q.push_back(mk_tx(8'hD8, 1, a, 0, 0));
            default: exp_q.push_back(mk_tx(8'hC7, 0, 0, 0, 0));
        endcase
        for (int i = 0; i < 1000; i++) begin
            f = (i < fsr_script.size()) ? fsr_script[i] : 8'h80;
            exp_q.push_back(mk_tx(8'h70, 0, 0, 1, 1));
            if (f[7]) begin
                m_err = f[4] | f[5];
                break;
            end
            if (i + 1 == int'(MAX_POLLS)) begin
                m_err = 1;
                m_to  = 1;
                break;
            end
        end
    endtask

    function automatic logic [7:0] next_fsr();
        if (fsr_idx < fsr_script.size()) begin
            fsr_idx++;
            return fsr_script[fsr_idx-1];
        end
        return 8'h80;
    endfunction

    // Issues one operation, plays the engine, and compares traffic and outcome.
    task automatic run_op(input logic [1:0] t, input logic [23:0] a, input logic [8:0] l,
                          input int dly, input bit hold, input bit abort_poll,
                          output bit g_err, output bit g_to, output int g_ntx);
        int   cyc, wait_cnt, done_cnt, last_done;
        bit   in_tx, done_seen, abort_next;
        logic [7:0] cur_cmd, cur_rdata;
        tx_t  x;
        model(t, a, l);
        got_q.delete();
        fsr_idx = 0;
        g_err = 0; g_to = 0;
        cyc = 0; wait_cnt = 0; done_cnt = 0; last_done = -1000;
        in_tx = 0; done_seen = 0; abort_next = 0;
        cur_cmd = 0; cur_rdata = 0;
        @(negedge clk);
        check("op_ready_idle", op_ready, 1);
        op_valid = 1; op_type = t; op_addr = a; op_len = l;
        @(posedge clk);
        while (!done_seen && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (abort_next) begin
                rst_ni = 1; eng_ready = 0; eng_done = 0; op_valid = 0;
                @(posedge clk);
                @(negedge clk);
                check("abort_eng_valid", eng_valid, 0);
                check("abort_op_ready", op_ready, 1);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                rst_ni = 0;
                g_ntx = got_q.size();
                return;
            end
            // Fields are don't-care after acceptance; scramble them.
            op_valid = hold; op_type = 2'($urandom); op_addr = 24'($urandom);
            op_len = 9'($urandom);
            eng_ready = 0; eng_done = 0; eng_rdata = 8'($urandom);
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) begin
                    eng_done = 1; eng_rdata = cur_rdata; last_done = cyc;
                    if (abort_poll && cur_cmd == 8'h70) abort_next = 1;
                end
            end
            if (cyc == 1 && !m_rej) check("wren_latency", eng_valid, 1);
            if (done) begin
                done_seen = 1; g_err = err; g_to = timeout;
                if (m_rej) check("reject_latency", cyc, 1);
            end else begin
                check("op_ready_busy", op_ready, 0);
                check("busy_high", busy, 1);
            end
            if (eng_valid) begin
                x = mk_tx(eng_cmd, eng_has_addr, eng_addr, eng_len, eng_dir);
                if (!in_tx) begin
                    got_q.push_back(x);
                    in_tx = 1;
                    wait_cnt = (got_q.size() == 1) ? dly : $urandom_range(0, 2);
                    if (x.cmd == 8'h70) check("poll_gap", cyc - last_done, POLL_GAP + 1);
                end else begin
                    check("stable_fields", {x.cmd, x.has_addr, x.addr[15:0], x.len, x.dir},
                          {got_q[$].cmd, got_q[$].has_addr, got_q[$].addr[15:0],
                           got_q[$].len, got_q[$].dir});
                end
                if (wait_cnt == 0) begin
                    eng_ready = 1; in_tx = 0; done_cnt = 2; cur_cmd = x.cmd;
                    cur_rdata = (x.cmd == 8'h70) ? next_fsr() : 8'($urandom);
                end else begin
                    wait_cnt--;
                end
            end
        end
        check("done_reached", done_seen, 1);
        g_ntx = got_q.size();
        check("tx_count", g_ntx, exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check("tx_cmd", got_q[i].cmd, exp_q[i].cmd);
            check("tx_has_addr", got_q[i].has_addr, exp_q[i].has_addr);
            if (exp_q[i].has_addr) check("tx_addr", got_q[i].addr, exp_q[i].addr);
            check("tx_len", got_q[i].len, exp_q[i].len);
            check("tx_dir", got_q[i].dir, exp_q[i].dir);
        end
        @(negedge clk);
        op_valid = 0; eng_ready = 0; eng_done = 0;
        check("done_one_cycle", done, 0);
        check("err_drop", err, 0);
        check("timeout_drop", timeout, 0);
        check("ready_after_done", op_ready, 1);
    endtask

    vec_t tbl[11];

    initial begin
        bit   ge, gt;
        int   gn;
        logic [1:0]  rt;
        logic [23:0] ra;
        logic [8:0]  rl;
        logic [7:0]  rf;

        //          t     addr          len     dly hold nf  fsr bytes (first first)      err to ntx
        tbl[0]  = '{2'd0, 24'h000100, 9'd16,  0, 0, 3, {8'h00,8'h00,8'h80,24'h0}, 0, 0, 5};
        tbl[1]  = '{2'd1, 24'h010000, 9'd0,   0, 0, 1, {8'hA0,40'h0},             1, 0, 3};
        tbl[2]  = '{2'd2, 24'h000000, 9'd0,   1, 0, 6, {48'h0},                   1, 1, 6};
        tbl[3]  = '{2'd0, 24'h0000F8, 9'd16,  0, 0, 0, {48'h0},                   1, 0, 0};
        tbl[4]  = '{2'd0, 24'h000200, 9'd0,   0, 0, 0, {48'h0},                   1, 0, 0};
        tbl[5]  = '{2'd0, 24'h123400, 9'd256, 2, 0, 0, {48'h0},                   0, 0, 3};
        tbl[6]  = '{2'd0, 24'h0000FF, 9'd1,   0, 0, 1, {8'hC0,40'h0},             0, 0, 3};
        tbl[7]  = '{2'd0, 24'h000000, 9'd257, 0, 0, 0, {48'h0},                   1, 0, 0};
        tbl[8]  = '{2'd3, 24'h000000, 9'd4,   0, 0, 0, {48'h0},                   1, 0, 0};
        tbl[9]  = '{2'd1, 24'hABCDEF, 9'd0,   5, 1, 1, {8'h90,40'h0},             1, 0, 3};
        tbl[10] = '{2'd2, 24'h000000, 9'd0,   0, 0, 4, {8'h00,8'h00,8'h00,8'h80,16'h0},
                    0, 0, 6};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_op_ready", op_ready, 1);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_timeout", timeout, 0);
        check("rst_busy", busy, 0);
        check("rst_eng_valid", eng_valid, 0);
        check("rst_eng_cmd", eng_cmd, 0);
        rst_ni = 0;

        for (int v = 0; v < 11; v++) begin
            fsr_script.delete();
            for (int k = 0; k < tbl[v].nf; k++) fsr_script.push_back(tbl[v].fb[k]);
            run_op(tbl[v].t, tbl[v].a, tbl[v].l, tbl[v].dly, tbl[v].hold, 0, ge, gt, gn);
            check($sformatf("vec%0d_err", v), ge, tbl[v].exp_err);
            check($sformatf("vec%0d_timeout", v), gt, tbl[v].exp_to);
            check($sformatf("vec%0d_ntx", v), gn, tbl[v].exp_ntx);
        end

        // Reset while waiting on a status poll, then a clean sector erase.
        fsr_script.delete();
        fsr_script.push_back(8'h00);
        fsr_script.push_back(8'h00);
        run_op(2'd1, 24'h020000, 9'd0, 0, 0, 1, ge, gt, gn);
        check("abort_ntx", gn, 3);
        fsr_script.delete();
        fsr_script.push_back(8'h00);
        fsr_script.push_back(8'h80);
        run_op(2'd1, 24'h030000, 9'd0, 0, 0, 0, ge, gt, gn);
        check("post_abort_err", ge, 0);
        check("post_abort_timeout", gt, 0);
        check("post_abort_ntx", gn, 4);

        for (int r = 0; r < 30; r++) begin
            rt = 2'($urandom_range(0, 3));
            ra = 24'($urandom);
            case ($urandom_range(0, 9))
                0:       rl = 9'd0;
                1:       rl = 9'($urandom_range(257, 511));
                default: rl = 9'($urandom_range(1, 256));
            endcase
            fsr_script.delete();
            for (int k = 0; k < int'($urandom_range(0, 5)); k++) begin
                rf = 8'($urandom) & 8'h7F;
                if ($urandom_range(0, 2) == 0) rf = rf | 8'h80;
                fsr_script.push_back(rf);
            end
            run_op(rt, ra, rl, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0, ge, gt, gn);
            check("rand_err", ge, m_err);
            check("rand_timeout", gt, m_to);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/qspi_flash_op_sequencer.md
Name: qspi_flash_op_sequencer

Overview:
Sequences multi-step flash operations (page program, sector erase, bulk erase) on top of the QSPI shift engine inside the flash controller. It accepts one high-level operation from the register/TL-UL front end and issues the required engine transactions: WREN (0x06), then PP (0x02), SE (0xD8) or BE (0xC7), then RFSR (0x70) polling until the flash reports ready. It reports completion, error and timeout back to the status register logic.

Parameters:
ADDR_W, 24, flash address width
POLL_GAP, 8, idle cycles between consecutive RFSR polls (>=1)
MAX_POLLS, 65535, RFSR polls allowed before timeout (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-high
op_valid_i  in  1  operation request
op_ready_o  out  1  sequencer can accept an operation
op_type_i  in  2  0=PP, 1=SE, 2=BE, 3=reserved
op_addr_i  in  ADDR_W  flash address (ignored for BE)
op_len_i  in  9  PP byte count, 1..256
done_o  out  1  one-cycle completion pulse
err_o  out  1  valid with done_o: rejected op, flash error or timeout
timeout_o  out  1  valid with done_o: poll limit reached
busy_o  out  1  high whenever state != IDLE
eng_valid_o  out  1  engine transaction request
eng_ready_i  in  1  engine accepts request
eng_cmd_o  out  8  opcode
eng_has_addr_o  out  1  address phase present
eng_addr_o  out  ADDR_W  address
eng_len_o  out  9  data bytes (0 = none)
eng_dir_o  out  1  0=write data, 1=read data
eng_done_i  in  1  engine transaction finished (one-cycle pulse)
eng_rdata_i  in  8  first read byte, valid with eng_done_i

Behaviour:
- Reset: state IDLE; op_ready_o=1; all other outputs 0; counters 0. Reset mid-operation aborts immediately; the sequencer does not attempt flash recovery.
- Handshake: operation accepted on op_valid_i && op_ready_o; op_ready_o=1 only in IDLE. Fields are latched at acceptance; inputs are don't-care afterwards.
- Engine handshake: eng_valid_o is held with stable eng_* fields until eng_ready_i. eng_done_i is honoured only in the *_WAIT states and ignored elsewhere.
- States:
  - IDLE: on accept, run validation. A rejected op goes to DONE with err_o. Otherwise go to WREN_ISSUE.
  - Validation (reject conditions): op_type=3; PP with op_len=0 or >256; PP where addr[7:0]+len>256 (page-wrap). Rejected ops produce no engine traffic; done_o+err_o occur the cycle after acceptance.
  - WREN_ISSUE: cmd 0x06, no addr, len 0. On ready go to WREN_WAIT.
  - WREN_WAIT: on eng_done_i go to OP_ISSUE.
  - OP_ISSUE: issue the selected opcode.
    - PP: has_addr=1, len=op_len, dir=0.
    - SE: has_addr=1, len 0.
    - BE: has_addr=0, len 0.
    - On ready go to OP_WAIT.
  - OP_WAIT: on eng_done_i, clear the poll counter and go to GAP.
  - GAP: wait POLL_GAP cycles, then go to POLL_ISSUE.
  - POLL_ISSUE: cmd 0x70, no addr, len 1, dir=1. On ready increment the poll counter and go to POLL_WAIT.
  - POLL_WAIT: on eng_done_i, evaluate FSR = eng_rdata_i.
    - bit7=1: flash ready. If bit4 (program err) or bit5 (erase err) is set, set err. Go to DONE.
    - bit7=0 and poll counter == MAX_POLLS: set err and timeout, go to DONE.
    - Otherwise go to GAP.
  - DONE: done_o=1 for exactly one cycle with err_o/timeout_o. Next cycle go to IDLE; err_o/timeout_o drop to 0.
- Latency: accept at cycle N; eng_valid_o for WREN rises at N+1.
- Simultaneous eng_ready_i and eng_done_i in an ISSUE state: ready is taken and done is ignored. The engine guarantees done comes later.
- Poll counter is 16 bits and saturates; it is never compared beyond MAX_POLLS.

Decomposition:
- Package qspi_seq_pkg holds:
  - opcode constants (WREN, PP, SE, BE, RFSR)
  - op_type enum
  - state enum
  - FSR bit indices (READY=7, ERASE_ERR=5, PROG_ERR=4)
- Sub-module qspi_poll_timer: GAP countdown plus saturating poll counter with a limit compare.

Test Plan:
- PP addr 0x000100, len 16; engine ready immediately; FSR 0x00 twice then 0x80 -> engine sees 0x06, then 0x02 with addr 0x100 len 16, then 3×0x70; done_o=1, err_o=0.
- SE addr 0x010000; FSR 0xA0 -> done_o=1, err_o=1, timeout_o=0.
- BE with MAX_POLLS=4; FSR stays 0x00 -> exactly 4 RFSR transactions, then done_o with err_o=1, timeout_o=1.
- PP addr 0x0000F8, len 16 (page-wrap), and a separate PP with len 0 -> no eng_valid_o; done_o+err_o the cycle after accept.
- eng_ready_i held low 5 cycles on WREN -> eng_valid_o and fields stable for all 5 cycles; op_ready_o=0; a second op_valid_i is not accepted.
- Assert rst_ni during POLL_WAIT -> next edge: IDLE, eng_valid_o=0, op_ready_o=1; a following SE completes normally.
